// File: rtl/rr_priority_arbiter_pkg.sv
// Shared definitions for the registered round-robin / fixed-priority arbiter:
// FSM state encodings and the grant-index width derivation.
package rr_priority_arbiter_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Index width for n requesters; a 2-entry arbiter still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_arbiter_checker.sv
// Grant-output invariants: one-hot while valid, all-zero while idle,
// and the one-hot vector always agreeing with the binary index.
module rr_priority_arbiter_checker #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             valid,
    input logic [IDX_W-1:0] gnt_idx,
    input logic [N-1:0]     gnt_onehot
);

    a_onehot_when_valid: assert property (@(posedge clk) disable iff (rst)
        valid |-> $onehot(gnt_onehot))
        else $error("gnt_onehot not one-hot while valid");

    a_zero_when_idle: assert property (@(posedge clk) disable iff (rst)
        !valid |-> (gnt_onehot == {N{1'b0}}))
        else $error("gnt_onehot nonzero while not valid");

    a_idx_matches: assert property (@(posedge clk) disable iff (rst)
        valid |-> (gnt_onehot == ({{(N-1){1'b0}}, 1'b1} << gnt_idx)))
        else $error("gnt_onehot disagrees with gnt_idx");

endmodule

// File: rtl/rr_priority_arbiter_mask_encoder.sv
// Combinational priority search: rotate req so that ptr sits at the top,
// pick the highest set bit, then map that position back to a requester index.
module rr_mask_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [2*N-1:0]   dbl_s;
    logic [N-1:0]     rot_s;
    logic [IDX_W-1:0] hit_s;
    logic [IDX_W:0]   sum_s;

    // rot_s[j] = req[(ptr + 1 + j) mod N], so rot_s[N-1] is req[ptr].
    always_comb begin
        dbl_s = ({req, req} >> ptr) >> 1;
        rot_s = dbl_s[N-1:0];
        found = 1'b0;
        hit_s = {IDX_W{1'b0}};
        for (int j = 0; j < N; j++) begin
            hit_s = rot_s[j] ? IDX_W'(j) : hit_s;
            found = found | rot_s[j];
        end
        sum_s = {1'b0, ptr} + {1'b0, hit_s} + (IDX_W+1)'(1);
        if (sum_s >= (IDX_W+1)'(N)) begin
            idx = IDX_W'(sum_s - (IDX_W+1)'(N));
        end else begin
            idx = sum_s[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter: grants one requester, holds the grant until ack,
// and re-arbitrates on the ack cycle so back-to-back grants have no bubble.
module rr_priority_arbiter
    import rr_priority_arbiter_pkg::*;
#(
    parameter int N           = 8,
    parameter int IDX_W       = idx_width(N),
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     req,
    input  logic             ack,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     gnt_onehot,
    output logic             valid
);

    localparam logic [IDX_W-1:0] PTR_MAX = IDX_W'(N - 1);

    logic [0:0]       state_r;
    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] ptr_next_s;
    logic [IDX_W-1:0] win_idx_s;
    logic [N-1:0]     win_onehot_s;
    logic             found_s;
    logic [IDX_W-1:0] gnt_idx_r;
    logic [N-1:0]     gnt_onehot_r;
    logic             valid_r;

    // On ack the served requester drops to lowest priority; the search in the
    // same cycle must already see that rotated pointer.
    always_comb begin
        if ((state_r == ST_GRANT) && ack && ROUND_ROBIN) begin
            ptr_next_s = (gnt_idx_r == {IDX_W{1'b0}}) ? PTR_MAX : gnt_idx_r - IDX_W'(1);
        end else begin
            ptr_next_s = ptr_r;
        end
        win_onehot_s = {{(N-1){1'b0}}, 1'b1} << win_idx_s;
    end

    rr_mask_encoder #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_enc (
        .req   (req),
        .ptr   (ptr_next_s),
        .idx   (win_idx_s),
        .found (found_s)
    );

    // Grant FSM, rotation pointer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            ptr_r        <= PTR_MAX;
            gnt_idx_r    <= {IDX_W{1'b0}};
            gnt_onehot_r <= {N{1'b0}};
            valid_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en && found_s) begin
                        gnt_idx_r    <= win_idx_s;
                        gnt_onehot_r <= win_onehot_s;
                        valid_r      <= 1'b1;
                        state_r      <= ST_GRANT;
                    end else begin
                        gnt_onehot_r <= {N{1'b0}};
                        valid_r      <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (ack) begin
                        ptr_r <= ptr_next_s;
                        if (en && found_s) begin
                            gnt_idx_r    <= win_idx_s;
                            gnt_onehot_r <= win_onehot_s;
                            valid_r      <= 1'b1;
                            state_r      <= ST_GRANT;
                        end else begin
                            gnt_onehot_r <= {N{1'b0}};
                            valid_r      <= 1'b0;
                            state_r      <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_GRANT;
                    end
                end
                default: begin
                    gnt_onehot_r <= {N{1'b0}};
                    valid_r      <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_idx    = gnt_idx_r;
    assign gnt_onehot = gnt_onehot_r;
    assign valid      = valid_r;

    rr_priority_arbiter_checker #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid_r),
        .gnt_idx    (gnt_idx_r),
        .gnt_onehot (gnt_onehot_r)
    );

endmodule
